// File: rtl/router_iact_mc.sv
// router_iact_mc: streams LEN GLB words (base/stride addressing) to every masked PE scratchpad,
// using a small skid FIFO to absorb the one-cycle GLB read latency.
module router_iact_mc #(
    parameter int DATA_BITWIDTH     = 16,
    parameter int ADDR_BITWIDTH_GLB = 10,
    parameter int NUM_DEST          = 4,
    parameter int LEN_BITWIDTH      = 8,
    parameter int BUF_DEPTH         = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic [ADDR_BITWIDTH_GLB-1:0] base_addr,
    input  logic [ADDR_BITWIDTH_GLB-1:0] stride,
    input  logic [LEN_BITWIDTH-1:0]      len,
    input  logic [NUM_DEST-1:0]          dest_mask,
    input  logic [DATA_BITWIDTH-1:0]     r_data_glb,
    output logic [ADDR_BITWIDTH_GLB-1:0] r_addr_glb,
    output logic                         read_req_glb,
    output logic [DATA_BITWIDTH-1:0]     w_data_spad,
    output logic [NUM_DEST-1:0]          load_en_spad,
    input  logic [NUM_DEST-1:0]          spad_ready,
    output logic                         busy,
    output logic                         done
);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int OW = $clog2(BUF_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t state, state_nxt;

    logic [DATA_BITWIDTH-1:0]     mem [BUF_DEPTH];
    logic [PW-1:0]                wr_ptr, rd_ptr;
    logic [OW-1:0]                occ;
    logic [OW:0]                  level;
    logic                         inflight, run, all_rdy, pop, push, issue;
    logic [ADDR_BITWIDTH_GLB-1:0] addr, stride_q;
    logic [LEN_BITWIDTH-1:0]      len_q, issued, sent;
    logic [NUM_DEST-1:0]          mask_q;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign run     = state == RUN;
    assign all_rdy = &(spad_ready | ~mask_q);
    assign pop     = run && occ != '0 && all_rdy && !abort;
    assign push    = run && inflight && !abort;
    // Reads still in flight count against FIFO space so a stall can never overflow it.
    assign level   = {1'b0, occ} + {{OW{1'b0}}, inflight} - {{OW{1'b0}}, pop};
    assign issue   = run && issued < len_q && !abort && level < (OW + 1)'(BUF_DEPTH);

    assign read_req_glb = issue;
    assign r_addr_glb   = addr;
    assign w_data_spad  = mem[rd_ptr];
    assign load_en_spad = mask_q & {NUM_DEST{run && occ != '0}};
    assign busy         = run;
    assign done         = state == FIN;

    always_comb begin
        state_nxt = state;
        if (state == IDLE)
            state_nxt = start ? ((len == '0) ? FIN : RUN) : IDLE;
        else if (state == RUN)
            state_nxt = abort ? IDLE : (pop && sent + LEN_BITWIDTH'(1) == len_q) ? FIN : RUN;
        else
            state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            inflight <= 1'b0;
            addr     <= '0;
            stride_q <= '0;
            len_q    <= '0;
            mask_q   <= '0;
            issued   <= '0;
            sent     <= '0;
            occ      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= issue;
            if (state == IDLE && start) begin
                addr     <= base_addr;
                stride_q <= stride;
                len_q    <= len;
                mask_q   <= dest_mask;
                issued   <= '0;
                sent     <= '0;
            end else begin
                if (issue) begin
                    addr   <= addr + stride_q;
                    issued <= issued + LEN_BITWIDTH'(1);
                end
                if (pop) sent <= sent + LEN_BITWIDTH'(1);
            end
            if (run && abort) begin
                occ    <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= r_data_glb;
                    wr_ptr      <= inc(wr_ptr);
                end
                if (pop) rd_ptr <= inc(rd_ptr);
                occ <= occ + OW'(push) - OW'(pop);
            end
        end
    end
endmodule
